// File: rtl/route_planner_seq_pkg.sv
// Shared types and constants for the route planner.
// Contents: port direction encoding, routing algorithm select, planner
// FSM states, per-input-port output bit indices, and a helper that
// folds a five-direction set into the 4-bit vector of one input port.
package route_planner_seq_pkg;

    localparam int unsigned ADDR_FIELD = 3;

    typedef enum logic [2:0] {
        PE    = 3'd0,
        X_POS = 3'd1,
        Y_POS = 3'd2,
        X_NEG = 3'd3,
        Y_NEG = 3'd4
    } port_dir_e;

    typedef enum logic [1:0] {
        ALGO_XY = 2'd0,
        ALGO_YX = 2'd1,
        ALGO_WF = 2'd2
    } algo_e;

    typedef enum logic [1:0] {
        RP_IDLE,
        RP_CALC,
        RP_HOLD
    } rp_state_e;

    // Output bit indices: the four directions other than the input port,
    // in ascending direction order.
    localparam int unsigned PE_XPOS   = 0, PE_YPOS   = 1, PE_XNEG   = 2, PE_YNEG   = 3;
    localparam int unsigned XPOS_PE   = 0, XPOS_YPOS = 1, XPOS_XNEG = 2, XPOS_YNEG = 3;
    localparam int unsigned YPOS_PE   = 0, YPOS_XPOS = 1, YPOS_XNEG = 2, YPOS_YNEG = 3;
    localparam int unsigned XNEG_PE   = 0, XNEG_XPOS = 1, XNEG_YPOS = 2, XNEG_YNEG = 3;
    localparam int unsigned YNEG_PE   = 0, YNEG_XPOS = 1, YNEG_YPOS = 2, YNEG_XNEG = 3;

    // Drops the input port's own direction (U-turn, or PE for the PE
    // port) and packs the remaining four directions into bits 0..3.
    function automatic logic [3:0] map_dirs(input port_dir_e port, input logic [4:0] dirs);
        logic [3:0] v;
        logic [2:0] k;
        v = '0;
        k = '0;
        for (int unsigned j = 0; j < 5; j++) begin
            if (j != 32'(port)) begin
                v[k[1:0]] = dirs[j];
                k = k + 3'd1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/route_planner_seq_route_compute_comb.sv
// Combinational route computation from a registered destination.
// Ports:
//   x_field, y_field : registered destination coordinates
//   channels         : productive output vector for PORT_DIR (4 bits)
//   illegal          : destination outside the mesh
import route_planner_seq_pkg::*;

module route_compute_comb #(
    parameter port_dir_e   PORT_DIR = X_POS,
    parameter int unsigned X_LOCAL  = 2,
    parameter int unsigned Y_LOCAL  = 2,
    parameter int unsigned ADDR_W   = ADDR_FIELD,
    parameter int unsigned X_MAX    = 3,
    parameter int unsigned Y_MAX    = 3,
    parameter algo_e       ALGO     = ALGO_XY
) (
    input  logic [ADDR_W-1:0] x_field,
    input  logic [ADDR_W-1:0] y_field,
    output logic [3:0]        channels,
    output logic              illegal
);

    logic [31:0] xw, yw;
    logic        xe, xp, xn, ye, yp, yn;
    logic [4:0]  dirs;

    // Zero-extend so comparisons against the 32-bit parameters are unsigned
    // over the full field width.
    assign xw = 32'(x_field);
    assign yw = 32'(y_field);

    assign xe = (xw == X_LOCAL);
    assign xp = (xw >  X_LOCAL);
    assign xn = (xw <  X_LOCAL);
    assign ye = (yw == Y_LOCAL);
    assign yp = (yw >  Y_LOCAL);
    assign yn = (yw <  Y_LOCAL);

    assign illegal = (xw > X_MAX) || (yw > Y_MAX);

    always_comb begin
        dirs = '0;
        if (xe && ye) begin
            dirs[PE] = 1'b1;
        end else begin
            case (ALGO)
                ALGO_XY: begin
                    if (xp)      dirs[X_POS] = 1'b1;
                    else if (xn) dirs[X_NEG] = 1'b1;
                    else if (yp) dirs[Y_POS] = 1'b1;
                    else if (yn) dirs[Y_NEG] = 1'b1;
                end
                ALGO_YX: begin
                    if (yp)      dirs[Y_POS] = 1'b1;
                    else if (yn) dirs[Y_NEG] = 1'b1;
                    else if (xp) dirs[X_POS] = 1'b1;
                    else if (xn) dirs[X_NEG] = 1'b1;
                end
                default: begin
                    // West-first: any westward hop must be taken first.
                    if (xn) begin
                        dirs[X_NEG] = 1'b1;
                    end else begin
                        dirs[X_POS] = xp;
                        dirs[Y_POS] = yp;
                        dirs[Y_NEG] = yn;
                    end
                end
            endcase
        end
    end

    assign channels = map_dirs(PORT_DIR, dirs);

endmodule

// File: rtl/route_planner_seq.sv
// Registered, packet-holding route planner for one mesh router input port.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   header_valid_din     : header present on x/y fields
//   header_ready_dout    : planner idle, can accept a header
//   x_field_din/y_field_din : destination coordinates
//   route_release_din    : packet forwarded, free the route
//   valid_channels_dout  : productive output channel vector
//   route_valid_dout     : vector holds a live route
//   route_error_dout     : one-cycle pulse on illegal/empty route
import route_planner_seq_pkg::*;

module route_planner_seq #(
    parameter port_dir_e   PORT_DIR = X_POS,
    parameter int unsigned X_LOCAL  = 2,
    parameter int unsigned Y_LOCAL  = 2,
    parameter int unsigned ADDR_W   = ADDR_FIELD,
    parameter int unsigned X_MAX    = 3,
    parameter int unsigned Y_MAX    = 3,
    parameter algo_e       ALGO     = ALGO_XY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              header_valid_din,
    output logic              header_ready_dout,
    input  logic [ADDR_W-1:0] x_field_din,
    input  logic [ADDR_W-1:0] y_field_din,
    input  logic              route_release_din,
    output logic [3:0]        valid_channels_dout,
    output logic              route_valid_dout,
    output logic              route_error_dout
);

    rp_state_e         state, state_next;
    logic [ADDR_W-1:0] x_q, y_q;
    logic [3:0]        comp_ch, chan_next;
    logic              comp_illegal, valid_next, err_next;

    route_compute_comb #(
        .PORT_DIR (PORT_DIR),
        .X_LOCAL  (X_LOCAL),
        .Y_LOCAL  (Y_LOCAL),
        .ADDR_W   (ADDR_W),
        .X_MAX    (X_MAX),
        .Y_MAX    (Y_MAX),
        .ALGO     (ALGO)
    ) u_compute (
        .x_field  (x_q),
        .y_field  (y_q),
        .channels (comp_ch),
        .illegal  (comp_illegal)
    );

    assign header_ready_dout = (state == RP_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= RP_IDLE;
            x_q                 <= '0;
            y_q                 <= '0;
            valid_channels_dout <= '0;
            route_valid_dout    <= 1'b0;
            route_error_dout    <= 1'b0;
        end else begin
            state               <= state_next;
            valid_channels_dout <= chan_next;
            route_valid_dout    <= valid_next;
            route_error_dout    <= err_next;
            if (state == RP_IDLE && header_valid_din) begin
                x_q <= x_field_din;
                y_q <= y_field_din;
            end
        end
    end

    always_comb begin
        state_next = state;
        chan_next  = valid_channels_dout;
        valid_next = route_valid_dout;
        err_next   = 1'b0;
        case (state)
            RP_IDLE: begin
                if (header_valid_din) state_next = RP_CALC;
            end
            RP_CALC: begin
                if (!comp_illegal && (comp_ch != '0)) begin
                    state_next = RP_HOLD;
                    chan_next  = comp_ch;
                    valid_next = 1'b1;
                end else begin
                    state_next = RP_IDLE;
                    chan_next  = '0;
                    valid_next = 1'b0;
                    err_next   = 1'b1;
                end
            end
            RP_HOLD: begin
                if (route_release_din) begin
                    state_next = RP_IDLE;
                    chan_next  = '0;
                    valid_next = 1'b0;
                end
            end
            default: begin
                state_next = RP_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_route_planner_seq.sv
// Directed bench for route_planner_seq across several port/algorithm configs.
import route_planner_seq_pkg::*;

module tb_route_planner_seq;

    logic       clk;
    logic       reset;
    logic       hv  [5];
    logic [2:0] xf  [5];
    logic [2:0] yf  [5];
    logic       rel [5];
    logic       rdy [5];
    logic [3:0] ch  [5];
    logic       rv  [5];
    logic       er  [5];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: X_NEG/XY   1: PE/XY   2: X_NEG/YX   3: PE/WF   4: Y_POS/XY
    route_planner_seq #(.PORT_DIR(X_NEG), .ALGO(ALGO_XY)) u_neg_xy (
        .clk(clk), .reset(reset), .header_valid_din(hv[0]), .header_ready_dout(rdy[0]),
        .x_field_din(xf[0]), .y_field_din(yf[0]), .route_release_din(rel[0]),
        .valid_channels_dout(ch[0]), .route_valid_dout(rv[0]), .route_error_dout(er[0]));
    route_planner_seq #(.PORT_DIR(PE), .ALGO(ALGO_XY)) u_pe_xy (
        .clk(clk), .reset(reset), .header_valid_din(hv[1]), .header_ready_dout(rdy[1]),
        .x_field_din(xf[1]), .y_field_din(yf[1]), .route_release_din(rel[1]),
        .valid_channels_dout(ch[1]), .route_valid_dout(rv[1]), .route_error_dout(er[1]));
    route_planner_seq #(.PORT_DIR(X_NEG), .ALGO(ALGO_YX)) u_neg_yx (
        .clk(clk), .reset(reset), .header_valid_din(hv[2]), .header_ready_dout(rdy[2]),
        .x_field_din(xf[2]), .y_field_din(yf[2]), .route_release_din(rel[2]),
        .valid_channels_dout(ch[2]), .route_valid_dout(rv[2]), .route_error_dout(er[2]));
    route_planner_seq #(.PORT_DIR(PE), .ALGO(ALGO_WF)) u_pe_wf (
        .clk(clk), .reset(reset), .header_valid_din(hv[3]), .header_ready_dout(rdy[3]),
        .x_field_din(xf[3]), .y_field_din(yf[3]), .route_release_din(rel[3]),
        .valid_channels_dout(ch[3]), .route_valid_dout(rv[3]), .route_error_dout(er[3]));
    route_planner_seq #(.PORT_DIR(Y_POS), .ALGO(ALGO_XY)) u_ypos_xy (
        .clk(clk), .reset(reset), .header_valid_din(hv[4]), .header_ready_dout(rdy[4]),
        .x_field_din(xf[4]), .y_field_din(yf[4]), .route_release_din(rel[4]),
        .valid_channels_dout(ch[4]), .route_valid_dout(rv[4]), .route_error_dout(er[4]));

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one header and check the CALC cycle and its outcome.
    task automatic run(input int i, input logic [2:0] x, input logic [2:0] y,
                       input logic [3:0] exp_ch, input bit exp_err);
        for (int k = 0; k < 20 && rdy[i] !== 1'b1; k++) tick();
        check("ready_before_hdr", 4'(rdy[i]), 4'd1);
        hv[i] = 1'b1; xf[i] = x; yf[i] = y;
        tick();
        hv[i] = 1'b0;
        check("calc_ready", 4'(rdy[i]), 4'd0);
        check("calc_valid", 4'(rv[i]), 4'd0);
        tick();
        if (exp_err) begin
            check("err_pulse", 4'(er[i]), 4'd1);
            check("err_valid", 4'(rv[i]), 4'd0);
            check("err_chan", ch[i], 4'd0);
            check("err_ready", 4'(rdy[i]), 4'd1);
            tick();
            check("err_cleared", 4'(er[i]), 4'd0);
        end else begin
            check("route_valid", 4'(rv[i]), 4'd1);
            check("route_chan", ch[i], exp_ch);
            check("route_no_err", 4'(er[i]), 4'd0);
            check("hold_ready", 4'(rdy[i]), 4'd0);
        end
    endtask

    task automatic release_route(input int i);
        rel[i] = 1'b1;
        tick();
        rel[i] = 1'b0;
        check("rel_ready", 4'(rdy[i]), 4'd1);
        check("rel_valid", 4'(rv[i]), 4'd0);
        check("rel_chan", ch[i], 4'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hv[i] = 1'b0; xf[i] = '0; yf[i] = '0; rel[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 5; i++) begin
            check("rst_ready", 4'(rdy[i]), 4'd1);
            check("rst_valid", 4'(rv[i]), 4'd0);
            check("rst_chan", ch[i], 4'd0);
            check("rst_err", 4'(er[i]), 4'd0);
        end
        tick(); tick();
        #3 reset = 1'b1;
        tick();

        // Reset while holding a route drops it immediately.
        run(0, 3'd3, 3'd2, 4'b0010, 1'b0);
        #3 reset = 1'b0;
        #1;
        check("midhold_rst_chan", ch[0], 4'd0);
        check("midhold_rst_valid", 4'(rv[0]), 4'd0);
        check("midhold_rst_ready", 4'(rdy[0]), 4'd1);
        #2 reset = 1'b1;
        tick();

        // XY from PE: east hop, route stays until released.
        run(1, 3'd3, 3'd0, 4'b0001, 1'b0);
        tick();
        check("hold_stable_chan", ch[1], 4'b0001);
        check("hold_stable_valid", 4'(rv[1]), 4'd1);
        release_route(1);
        run(1, 3'd2, 3'd2, 4'd0, 1'b1);   // PE destination from PE port: empty
        run(1, 3'd1, 3'd4, 4'd0, 1'b1);   // y beyond Y_MAX

        // YX from X_NEG.
        run(2, 3'd3, 3'd0, 4'b1000, 1'b0);
        release_route(2);
        run(2, 3'd3, 3'd2, 4'b0010, 1'b0);
        release_route(2);

        // West-first from PE: (3,3) legal at the mesh corner.
        run(3, 3'd3, 3'd3, 4'b0011, 1'b0);
        release_route(3);
        run(3, 3'd1, 3'd3, 4'b0100, 1'b0);
        release_route(3);

        // U-turn and out-of-mesh x on X_NEG/XY.
        run(0, 3'd1, 3'd2, 4'd0, 1'b1);
        run(0, 3'd5, 3'd1, 4'd0, 1'b1);

        // Second header presented during HOLD waits for the release.
        run(4, 3'd3, 3'd3, 4'b0010, 1'b0);
        hv[4] = 1'b1; xf[4] = 3'd2; yf[4] = 3'd2;
        tick();
        check("busy_ready", 4'(rdy[4]), 4'd0);
        check("busy_chan", ch[4], 4'b0010);
        check("busy_valid", 4'(rv[4]), 4'd1);
        tick();
        check("busy_chan2", ch[4], 4'b0010);
        rel[4] = 1'b1;
        tick();
        rel[4] = 1'b0;
        check("busy_rel_ready", 4'(rdy[4]), 4'd1);
        check("busy_rel_valid", 4'(rv[4]), 4'd0);
        tick();
        hv[4] = 1'b0;
        check("second_calc_ready", 4'(rdy[4]), 4'd0);
        tick();
        check("second_valid", 4'(rv[4]), 4'd1);
        check("second_chan", ch[4], 4'b0001);
        release_route(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
